// File: rtl/result_byte_scanner_pkg.sv
// Shared constants and types for the result display path: word geometry,
// scanner state encoding and default timing parameters.
package result_byte_scanner_pkg;

    localparam int BYTES_PER_WORD = 32;
    localparam int BYTE_IDX_W     = 5;
    localparam int DEF_TICK_DIV   = 25_000_000;
    localparam int DEF_RD_LAT     = 2;

    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SHOW = 2'd2,
        ST_DONE = 2'd3
    } scan_state_e;

    function automatic logic [7:0] byte_of(input logic [8*BYTES_PER_WORD-1:0] word,
                                           input logic [BYTE_IDX_W-1:0]       idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/result_byte_scanner_tick_divider.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks;
// clear holds the count at zero so the first tick lands TICK_DIV-1 cycles later.
module tick_divider
    import result_byte_scanner_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CNT_W'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/result_byte_scanner.sv
// Reads one result word from RAM on start and steps its bytes onto the LEDs,
// low byte first, one byte per display tick; stops after one pass or loops.
module result_byte_scanner
    import result_byte_scanner_pkg::*;
#(
    parameter int DATA_W   = 256,
    parameter int ADDR_W   = 8,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  loop_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    output logic [ADDR_W-1:0]     ram_addr_o,
    input  logic [DATA_W-1:0]     ram_data_i,
    output logic [7:0]            leds_o,
    output logic [BYTE_IDX_W-1:0] byte_idx_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int WORD_W = 8 * BYTES_PER_WORD;
    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    scan_state_e           state_q, state_d;
    logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [7:0]            leds_q, leds_d;
    logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic                  wait_last;
    logic                  tick;

    assign wait_last = (wait_cnt_q == WAIT_W'(RD_LAT - 1));

    // Held clear outside SHOW, so entering SHOW always starts a fresh byte period.
    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (state_q != ST_SHOW),
        .tick_o  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start_i) state_d = ST_WAIT;
            ST_WAIT:          if (wait_last) state_d = ST_SHOW;
            ST_SHOW:          if (tick && byte_idx_q == LAST_BYTE && !loop_i) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == ST_WAIT) || (state_q == ST_SHOW);
        done_o = (state_q == ST_DONE);
    end

    always_comb begin
        ram_addr_d = ram_addr_q;
        wait_cnt_d = wait_cnt_q;
        word_d     = word_q;
        leds_d     = leds_q;
        byte_idx_d = byte_idx_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    ram_addr_d = base_addr_i;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (wait_last) begin
                    word_d     = ram_data_i[WORD_W-1:0];
                    leds_d     = ram_data_i[7:0];
                    byte_idx_d = '0;
                end
            end
            ST_SHOW: begin
                if (tick) begin
                    if (byte_idx_q != LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end else if (loop_i) begin
                        byte_idx_d = '0;
                    end
                    leds_d = byte_of(word_q, byte_idx_d);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr_q <= '0;
            wait_cnt_q <= '0;
            word_q     <= '0;
            leds_q     <= '0;
            byte_idx_q <= '0;
        end else begin
            ram_addr_q <= ram_addr_d;
            wait_cnt_q <= wait_cnt_d;
            word_q     <= word_d;
            leds_q     <= leds_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    assign ram_addr_o = ram_addr_q;
    assign leds_o     = leds_q;
    assign byte_idx_o = byte_idx_q;

endmodule

// File: tb/tb_result_byte_scanner.sv
// Scoreboard bench: stimulus queues every expected output change with its
// cycle number; the monitor pops and compares on each observed change.
module tb_result_byte_scanner;

    localparam int TD = 4;
    localparam int RL = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         loop = 1'b0;
    logic [7:0]   base_addr = 8'd0;
    logic [7:0]   ram_addr;
    logic [255:0] ram_data;
    logic [255:0] ram_q;
    logic [255:0] word_seq;
    logic [7:0]   leds;
    logic [4:0]   byte_idx;
    logic         busy;
    logic         done;

    result_byte_scanner #(
        .DATA_W   (256),
        .ADDR_W   (8),
        .RD_LAT   (RL),
        .TICK_DIV (TD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .loop_i      (loop),
        .base_addr_i (base_addr),
        .ram_addr_o  (ram_addr),
        .ram_data_i  (ram_data),
        .leds_o      (leds),
        .byte_idx_o  (byte_idx),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM with RD_LAT=2: one register stage after the registered address.
    initial begin
        for (int b = 0; b < 32; b++) word_seq[8*b +: 8] = 8'(b);
    end
    always @(posedge clk) begin
        if (ram_addr == 8'd2)      ram_q <= word_seq;
        else if (ram_addr == 8'd3) ram_q <= {32{8'hAA}};
        else                       ram_q <= '0;
    end
    assign ram_data = ram_q;

    typedef struct {
        int         c;
        logic [7:0] addr;
        logic [7:0] leds;
        logic [4:0] idx;
        logic       busy;
        logic       done;
    } snap_t;

    snap_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    bit    mon_en = 0;

    task automatic push(input int c, input logic [7:0] a, input logic [7:0] l,
                        input logic [4:0] i, input logic b, input logic d);
        snap_t s;
        s.c = c; s.addr = a; s.leds = l; s.idx = i; s.busy = b; s.done = d;
        exp_q.push_back(s);
    endtask

    function automatic bit same_out(input snap_t a, input snap_t b);
        return (a.addr === b.addr) && (a.leds === b.leds) && (a.idx === b.idx)
            && (a.busy === b.busy) && (a.done === b.done);
    endfunction

    initial begin : monitor
        snap_t prev, cur, e;
        bit have;
        have = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur.c = cyc; cur.addr = ram_addr; cur.leds = leds;
                cur.idx = byte_idx; cur.busy = busy; cur.done = done;
                if (!have || !same_out(cur, prev)) begin
                    have = 1;
                    prev = cur;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_change cyc=%0d got addr=%h leds=%h idx=%0d busy=%b done=%b, expected no change",
                                 cur.c, cur.addr, cur.leds, cur.idx, cur.busy, cur.done);
                    end else begin
                        e = exp_q.pop_front();
                        if (!same_out(cur, e) || (e.c >= 0 && e.c != cur.c)) begin
                            fails++;
                            $display("FAIL snapshot got cyc=%0d addr=%h leds=%h idx=%0d busy=%b done=%b, required cyc=%0d addr=%h leds=%h idx=%0d busy=%b done=%b",
                                     cur.c, cur.addr, cur.leds, cur.idx, cur.busy, cur.done,
                                     e.c, e.addr, e.leds, e.idx, e.busy, e.done);
                        end else begin
                            $display("[TB] ok cyc=%0d addr=%h leds=%h idx=%0d busy=%b done=%b",
                                     cur.c, cur.addr, cur.leds, cur.idx, cur.busy, cur.done);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [7:0] a, input logic lp);
        base_addr = a;
        loop      = lp;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    initial begin : stim
        int k;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push(-1, 8'h00, 8'h00, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1 mon_en = 1;
        repeat (3) @(negedge clk);

        // Single pass over word 2, with an ignored start (base 5) during SHOW.
        k = cyc + 1;
        push(k, 8'd2, 8'h00, 5'd0, 1'b1, 1'b0);
        for (int n = 1; n < 32; n++) push(k + RL + TD*n, 8'd2, 8'(n), 5'(n), 1'b1, 1'b0);
        push(k + RL + TD*32, 8'd2, 8'h1F, 5'd31, 1'b0, 1'b1);
        pulse_start(8'd2, 1'b0);
        wait_cyc(k + 20);
        pulse_start(8'd5, 1'b0);
        wait_cyc(k + 136);

        // Restart from DONE with word 3 (all 0xAA).
        k = cyc + 1;
        push(k, 8'd3, 8'h1F, 5'd31, 1'b1, 1'b0);
        push(k + RL, 8'd3, 8'hAA, 5'd0, 1'b1, 1'b0);
        for (int n = 1; n < 32; n++) push(k + RL + TD*n, 8'd3, 8'hAA, 5'(n), 1'b1, 1'b0);
        push(k + RL + TD*32, 8'd3, 8'hAA, 5'd31, 1'b0, 1'b1);
        pulse_start(8'd3, 1'b0);
        wait_cyc(k + 134);

        // Looping pass over word 2, then async reset while byte 7 is shown.
        k = cyc + 1;
        push(k, 8'd2, 8'hAA, 5'd31, 1'b1, 1'b0);
        push(k + RL, 8'd2, 8'h00, 5'd0, 1'b1, 1'b0);
        for (int n = 1; n < 32; n++) push(k + RL + TD*n, 8'd2, 8'(n), 5'(n), 1'b1, 1'b0);
        for (int n = 0; n < 8; n++) push(k + RL + TD*32 + TD*n, 8'd2, 8'(n), 5'(n), 1'b1, 1'b0);
        push(k + 160, 8'd0, 8'h00, 5'd0, 1'b0, 1'b0);
        pulse_start(8'd2, 1'b1);
        wait_cyc(k + 159);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        loop  = 1'b0;
        repeat (2) @(negedge clk);

        // Clean restart after reset.
        k = cyc + 1;
        push(k, 8'd2, 8'h00, 5'd0, 1'b1, 1'b0);
        for (int n = 1; n < 6; n++) push(k + RL + TD*n, 8'd2, 8'(n), 5'(n), 1'b1, 1'b0);
        pulse_start(8'd2, 1'b0);
        wait_cyc(k + RL + TD*5 + 2);
        @(negedge clk);
        mon_en = 0;

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_expectations got %0d left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
